// File: rtl/beam_scan_engine.sv
// beam_scan_engine
// Delay-and-sum beam scanner. When started it snapshots NUM_CH FFT channels at
// one bin. For every steering beam it forms the complex sum of coef*X over the
// channels and its power |sum|^2. It reports the strongest beam, that beam's
// DOA angle and its power.
// Optional feature: define BEAM_STREAM_EN to add a per-beam power stream
// (beam_valid_o / beam_idx_o / beam_pwr_o). With the macro undefined those
// ports and their registers do not exist.
module beam_scan_engine #(
    parameter int NUM_CH    = 4,
    parameter int NUM_BEAMS = 37,
    parameter int CW        = 14,
    parameter int ACC_W     = 32,
    parameter int FFT_LAT   = 2,
    parameter int ANG_MIN   = -90,
    parameter int ANG_STEP  = 5
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  start_i,
    input  logic [9:0]                            maxbin_i,
    output logic [9:0]                            fft_rdaddr_o,
    input  logic [NUM_CH*2*CW-1:0]                fft_q_i,
    output logic [$clog2(NUM_BEAMS*NUM_CH)-1:0]   coef_addr_o,
    input  logic [2*CW-1:0]                       coef_q_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [5:0]                            best_beam_o,
    output logic signed [7:0]                     doa_o,
    output logic [2*ACC_W:0]                      best_pwr_o
`ifdef BEAM_STREAM_EN
    ,
    output logic                                  beam_valid_o,
    output logic [5:0]                            beam_idx_o,
    output logic [2*ACC_W:0]                      beam_pwr_o
`endif
);

    localparam int CAW = $clog2(NUM_BEAMS * NUM_CH);
    localparam int CHW = $clog2(NUM_CH + 1);
    localparam int FW  = $clog2(FFT_LAT + 1);
    localparam int SW  = 2 * CW;
    localparam int PW  = 2 * CW + 1;
    localparam int QW  = 2 * ACC_W + 1;

    localparam logic [5:0]      LAST_BEAM  = 6'(NUM_BEAMS - 1);
    localparam logic [CHW-1:0]  MAC_LAST   = CHW'(NUM_CH);
    localparam logic [CHW-1:0]  ADDR_LAST  = CHW'(NUM_CH - 1);
    localparam logic [FW-1:0]   FETCH_LAST = FW'(FFT_LAT - 1);
    localparam logic signed [8:0] ANG_MIN_9  = 9'(ANG_MIN);
    localparam logic signed [8:0] ANG_STEP_9 = 9'(ANG_STEP);
    localparam logic signed [7:0] ANG_MIN_8  = 8'(ANG_MIN);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, PWR, DONE} state_t;

    state_t                  state_q;
    logic [FW-1:0]           fetch_cnt_q;
    logic [CHW-1:0]          ch_cnt_q;
    logic [5:0]              beam_q;
    logic [NUM_CH*SW-1:0]    snap_q;
    logic signed [ACC_W-1:0] acc_re_q;
    logic signed [ACC_W-1:0] acc_im_q;
    logic [9:0]              fft_rdaddr_q;
    logic [CAW-1:0]          coef_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic [5:0]              best_beam_q;
    logic signed [7:0]       doa_q;
    logic [QW-1:0]           best_pwr_q;
`ifdef BEAM_STREAM_EN
    logic                    beam_valid_q;
    logic [5:0]              beam_idx_q;
    logic [QW-1:0]           beam_pwr_q;
`endif

    logic signed [PW-1:0]      coef_re, coef_im, snap_re, snap_im;
    logic signed [PW-1:0]      prod_re, prod_im;
    logic signed [2*ACC_W-1:0] acc_re_w, acc_im_w, sq_re, sq_im;
    logic [QW-1:0]             pwr;

    // Steering angle of a beam: 9-bit signed arithmetic, truncated to 8 bits
    function automatic logic signed [7:0] doaOf(input logic [5:0] beam);
        logic signed [8:0] wide;
        wide = ANG_MIN_9 + ANG_STEP_9 * $signed({3'b000, beam});
        return wide[7:0];
    endfunction

    // Complex product of the current coefficient with the snapshot word at the head of the rotation, and power of the accumulator
    always_comb begin
        coef_re  = PW'($signed(coef_q_i[SW-1:CW]));
        coef_im  = PW'($signed(coef_q_i[CW-1:0]));
        snap_re  = PW'($signed(snap_q[SW-1:CW]));
        snap_im  = PW'($signed(snap_q[CW-1:0]));
        prod_re  = coef_re * snap_re - coef_im * snap_im;
        prod_im  = coef_re * snap_im + coef_im * snap_re;
        acc_re_w = (2*ACC_W)'(acc_re_q);
        acc_im_w = (2*ACC_W)'(acc_im_q);
        sq_re    = acc_re_w * acc_re_w;
        sq_im    = acc_im_w * acc_im_w;
        pwr      = {1'b0, sq_re} + {1'b0, sq_im};
    end

    // Scan FSM with its datapath; every output is a register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            fetch_cnt_q  <= '0;
            ch_cnt_q     <= '0;
            beam_q       <= '0;
            snap_q       <= '0;
            acc_re_q     <= '0;
            acc_im_q     <= '0;
            fft_rdaddr_q <= '0;
            coef_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_beam_q  <= '0;
            doa_q        <= ANG_MIN_8;
            best_pwr_q   <= '0;
`ifdef BEAM_STREAM_EN
            beam_valid_q <= 1'b0;
            beam_idx_q   <= '0;
            beam_pwr_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef BEAM_STREAM_EN
            beam_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        fft_rdaddr_q <= maxbin_i;
                        busy_q       <= 1'b1;
                        best_pwr_q   <= '0;
                        best_beam_q  <= '0;
                        doa_q        <= ANG_MIN_8;
                        beam_q       <= '0;
                        acc_re_q     <= '0;
                        acc_im_q     <= '0;
                        coef_addr_q  <= '0;
                        fetch_cnt_q  <= '0;
                        ch_cnt_q     <= '0;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_cnt_q == FETCH_LAST) begin
                        snap_q   <= fft_q_i;
                        ch_cnt_q <= '0;
                        state_q  <= MAC;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + FW'(1);
                    end
                end
                MAC: begin
                    // Coefficient data lags its address by one cycle, so slot 0 only issues an address
                    if (ch_cnt_q != '0) begin
                        acc_re_q <= acc_re_q + ACC_W'(prod_re);
                        acc_im_q <= acc_im_q + ACC_W'(prod_im);
                        snap_q   <= {snap_q[SW-1:0], snap_q[NUM_CH*SW-1:SW]};
                    end
                    if (ch_cnt_q < ADDR_LAST) begin
                        coef_addr_q <= coef_addr_q + CAW'(1);
                    end
                    if (ch_cnt_q == MAC_LAST) begin
                        ch_cnt_q <= '0;
                        state_q  <= PWR;
                    end else begin
                        ch_cnt_q <= ch_cnt_q + CHW'(1);
                    end
                end
                PWR: begin
                    if (pwr > best_pwr_q) begin
                        best_pwr_q  <= pwr;
                        best_beam_q <= beam_q;
                        doa_q       <= doaOf(beam_q);
                    end
`ifdef BEAM_STREAM_EN
                    beam_valid_q <= 1'b1;
                    beam_idx_q   <= beam_q;
                    beam_pwr_q   <= pwr;
`endif
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                    if (beam_q == LAST_BEAM) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        beam_q      <= beam_q + 6'd1;
                        coef_addr_q <= coef_addr_q + CAW'(1);
                        state_q     <= MAC;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fft_rdaddr_o = fft_rdaddr_q;
    assign coef_addr_o  = coef_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign best_beam_o  = best_beam_q;
    assign doa_o        = doa_q;
    assign best_pwr_o   = best_pwr_q;
`ifdef BEAM_STREAM_EN
    assign beam_valid_o = beam_valid_q;
    assign beam_idx_o   = beam_idx_q;
    assign beam_pwr_o   = beam_pwr_q;
`endif

endmodule

// File: tb/tb_beam_scan_engine.sv
// Testbench for beam_scan_engine with default parameters.
// Models the FFT RAM and coefficient ROM. It computes expected beam powers
// directly from the delay-and-sum definition.
module tb_beam_scan_engine;

   localparam int NUM_CH    = 4;
   localparam int NUM_BEAMS = 37;
   localparam int CW        = 14;
   localparam int ACC_W     = 32;
   localparam int CAW       = $clog2(NUM_BEAMS * NUM_CH);
   localparam int LATENCY   = 225;

   logic                       clk = 1'b0;
   logic                       resetN;
   logic                       start;
   logic [9:0]                 maxbin;
   logic [9:0]                 fftRdaddr;
   logic [NUM_CH*2*CW-1:0]     fftQ;
   logic [CAW-1:0]             coefAddr;
   logic [2*CW-1:0]            coefQ;
   logic                       busy;
   logic                       done;
   logic [5:0]                 bestBeam;
   logic [7:0]                 doa;
   logic [2*ACC_W:0]           bestPwr;
`ifdef BEAM_STREAM_EN
   logic                       beamValid;
   logic [5:0]                 beamIdx;
   logic [2*ACC_W:0]           beamPwr;
   int                         idxQ[$];
   logic [2*ACC_W:0]           pwrQ[$];
`endif

   logic [2*CW-1:0]            coefMem [NUM_BEAMS*NUM_CH];
   logic [NUM_CH*2*CW-1:0]     specMem [1024];
   int                         chRe [NUM_CH];
   int                         chIm [NUM_CH];

   int cycCnt = 0;
   int doneCnt = 0;
   int scansDone = 0;
   int checkCnt = 0;
   int errCnt = 0;

   beam_scan_engine dut (
      .clk_i        (clk),
      .reset_n_i    (resetN),
      .start_i      (start),
      .maxbin_i     (maxbin),
      .fft_rdaddr_o (fftRdaddr),
      .fft_q_i      (fftQ),
      .coef_addr_o  (coefAddr),
      .coef_q_i     (coefQ),
      .busy_o       (busy),
      .done_o       (done),
      .best_beam_o  (bestBeam),
      .doa_o        (doa),
      .best_pwr_o   (bestPwr)
`ifdef BEAM_STREAM_EN
      ,
      .beam_valid_o (beamValid),
      .beam_idx_o   (beamIdx),
      .beam_pwr_o   (beamPwr)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure start-to-done latency
   always @(posedge clk) cycCnt <= cycCnt + 1;

   // Memory models: registered reads of the FFT RAM and coefficient ROM
   always @(posedge clk) begin
      fftQ  <= specMem[int'(fftRdaddr)];
      coefQ <= coefMem[int'(coefAddr)];
   end

   // Count every done pulse so stray or missing pulses are visible
   always @(negedge clk) if (done) doneCnt <= doneCnt + 1;

`ifdef BEAM_STREAM_EN
   // Collect the per-beam stream
   always @(negedge clk) begin
      if (beamValid) begin
         idxQ.push_back(int'(beamIdx));
         pwrQ.push_back(beamPwr);
      end
   end
`endif

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
      checkCnt++;
      if (observed !== expected) begin
         errCnt++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference power of one beam: |sum over channels of coef*X|^2, 32-bit wrapping sums
   function automatic logic [64:0] beamPower(input int b);
      int accRe, accIm, cr, ci;
      accRe = 0;
      accIm = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         cr = int'($signed(coefMem[b*NUM_CH+ch][27:14]));
         ci = int'($signed(coefMem[b*NUM_CH+ch][13:0]));
         accRe += cr * chRe[ch] - ci * chIm[ch];
         accIm += cr * chIm[ch] + ci * chRe[ch];
      end
      return 65'(longint'(accRe) * longint'(accRe)) + 65'(longint'(accIm) * longint'(accIm));
   endfunction

   function automatic logic [7:0] angleOf(input int b);
      return 8'(-90 + 5 * b);
   endfunction

   task automatic computeExpected(output int expBeam, output logic [64:0] expPwr);
      logic [64:0] p;
      expBeam = 0;
      expPwr  = '0;
      for (int b = 0; b < NUM_BEAMS; b++) begin
         p = beamPower(b);
         if (p > expPwr) begin
            expPwr  = p;
            expBeam = b;
         end
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < NUM_BEAMS*NUM_CH; i++) coefMem[i] = '0;
   endtask

   task automatic setBeamCoef(input int b, input int re, input int im);
      for (int ch = 0; ch < NUM_CH; ch++) coefMem[b*NUM_CH+ch] = {14'(re), 14'(im)};
   endtask

   // Random contents everywhere, the modelled channel values at the chosen bin
   task automatic loadSpectrum(input int bin);
      logic [NUM_CH*2*CW-1:0] w;
      for (int i = 0; i < 1024; i++) specMem[i] = 112'({$urandom, $urandom, $urandom, $urandom});
      for (int ch = 0; ch < NUM_CH; ch++) w[ch*2*CW +: 2*CW] = {14'(chRe[ch]), 14'(chIm[ch])};
      specMem[bin] = w;
   endtask

   // Start a scan and wait, bounded, for done; optionally poke start mid-scan
   task automatic applyStimulus(input logic [9:0] bin, input bit inject, output int latency);
      int startCycle, n, rel;
      bit found;
      logic [NUM_CH*2*CW-1:0] saved;
`ifdef BEAM_STREAM_EN
      idxQ.delete();
      pwrQ.delete();
`endif
      saved = specMem[bin];
      maxbin = bin;
      start = 1'b1;
      startCycle = cycCnt;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      n = 0;
      latency = -1;
      while (!found && n < 2*LATENCY) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            latency = cycCnt - startCycle;
         end else begin
            @(posedge clk); #1;
            n++;
            rel = cycCnt - startCycle;
            start = inject && (rel == 50 || rel == 224);
            if (rel == 10) specMem[bin] = ~specMem[bin];
         end
      end
      start = 1'b0;
      specMem[bin] = saved;
      checkOutput("scanDone", 65'(found), 65'(1));
      if (found) scansDone++;
   endtask

   // Results at the done cycle, then busy release and the beam stream
   task automatic checkResults(input int expBeam, input logic [64:0] expPwr, input int latency);
`ifdef BEAM_STREAM_EN
      logic [64:0] maxPwr;
`endif
      checkOutput("latency", 65'(latency), 65'(LATENCY));
      checkOutput("bestBeam", 65'(bestBeam), 65'(expBeam));
      checkOutput("doa", 65'(doa), 65'(angleOf(expBeam)));
      checkOutput("bestPwr", bestPwr, expPwr);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busyClear", 65'(busy), 65'(0));
`ifdef BEAM_STREAM_EN
      checkOutput("streamCount", 65'(idxQ.size()), 65'(NUM_BEAMS));
      maxPwr = '0;
      foreach (idxQ[i]) begin
         checkOutput("streamIdx", 65'(idxQ[i]), 65'(i));
         checkOutput("streamPwr", pwrQ[i], beamPower(i));
         if (pwrQ[i] > maxPwr) maxPwr = pwrQ[i];
      end
      checkOutput("streamMax", maxPwr, expPwr);
`endif
   endtask

   task automatic randomSetup();
      for (int i = 0; i < NUM_BEAMS*NUM_CH; i++) coefMem[i] = 28'($urandom);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         chRe[ch] = int'($signed(14'($urandom)));
         chIm[ch] = int'($signed(14'($urandom)));
      end
   endtask

   // Main sequence
   initial begin
      int lat, expBeam, bin, snapDone;
      logic [64:0] expPwr;

      resetN = 1'b1;
      start  = 1'b0;
      maxbin = '0;
      clearRom();
      for (int ch = 0; ch < NUM_CH; ch++) begin chRe[ch] = 0; chIm[ch] = 0; end
      loadSpectrum(0);
      #2 resetN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstBusy", 65'(busy), 65'(0));
      checkOutput("rstDone", 65'(done), 65'(0));
      checkOutput("rstBeam", 65'(bestBeam), 65'(0));
      checkOutput("rstDoa", 65'(doa), 65'(8'd166));
      checkOutput("rstPwr", bestPwr, 65'(0));
      checkOutput("rstRdaddr", 65'(fftRdaddr), 65'(0));
      checkOutput("rstCoefAddr", 65'(coefAddr), 65'(0));
      @(posedge clk); #1;
      resetN = 1'b1;
      @(posedge clk); #1;

      $display("[TB] single steered beam 12");
      clearRom();
      setBeamCoef(12, 1, 0);
      for (int ch = 0; ch < NUM_CH; ch++) begin chRe[ch] = 100; chIm[ch] = 0; end
      loadSpectrum(37);
      applyStimulus(10'd37, 1'b0, lat);
      checkOutput("rdaddr", 65'(fftRdaddr), 65'(37));
      start = 1'b1;
      checkResults(12, 65'(160000), lat);
      snapDone = doneCnt;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("startInDoneIgnored", 65'(busy), 65'(0));
      checkOutput("noExtraDone", 65'(doneCnt), 65'(snapDone));

      $display("[TB] equal power tie beams 7 and 20");
      clearRom();
      setBeamCoef(7, 1, 0);
      setBeamCoef(20, 1, 0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         chRe[ch] = int'($urandom_range(1, 2000));
         chIm[ch] = int'($urandom_range(0, 2000));
      end
      loadSpectrum(500);
      computeExpected(expBeam, expPwr);
      applyStimulus(10'd500, 1'b0, lat);
      checkResults(7, expPwr, lat);

      $display("[TB] full-scale inputs on beam 36");
      clearRom();
      setBeamCoef(36, 8191, 8191);
      for (int ch = 0; ch < NUM_CH; ch++) begin chRe[ch] = -8192; chIm[ch] = -8192; end
      loadSpectrum(1023);
      computeExpected(expBeam, expPwr);
      checkOutput("modelFullScale", expPwr, (65'(1) << 58) - (65'(1) << 46) + (65'(1) << 32));
      applyStimulus(10'd1023, 1'b0, lat);
      checkResults(36, expPwr, lat);

      $display("[TB] start pulses during a scan");
      randomSetup();
      bin = int'($urandom_range(0, 1023));
      loadSpectrum(bin);
      computeExpected(expBeam, expPwr);
      snapDone = doneCnt;
      applyStimulus(10'(bin), 1'b1, lat);
      checkResults(expBeam, expPwr, lat);
      applyStimulus(10'(bin), 1'b0, lat);
      checkResults(expBeam, expPwr, lat);
      checkOutput("twoScansTwoDones", 65'(doneCnt - snapDone), 65'(2));

      $display("[TB] reset in the middle of a scan");
      maxbin = 10'(bin);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("midRstBusy", 65'(busy), 65'(0));
      checkOutput("midRstDone", 65'(done), 65'(0));
      checkOutput("midRstDoa", 65'(doa), 65'(8'd166));
      checkOutput("midRstBeam", 65'(bestBeam), 65'(0));
      checkOutput("midRstPwr", bestPwr, 65'(0));
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      checkOutput("idleAfterRst", 65'(busy), 65'(0));
      checkOutput("noDoneAfterRst", 65'(doneCnt), 65'(scansDone));

      $display("[TB] random scans");
      for (int it = 0; it < 3; it++) begin
         randomSetup();
         bin = int'($urandom_range(0, 1023));
         loadSpectrum(bin);
         computeExpected(expBeam, expPwr);
         applyStimulus(10'(bin), 1'b0, lat);
         checkResults(expBeam, expPwr, lat);
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("doneCount", 65'(doneCnt), 65'(scansDone));

      $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
      $finish;
   end

endmodule
